pipeline_word_serializer: RTL and testbench
===========================================

// Module: pipeline_word_serializer
//
// PURPOSE
// - Consumes wide words from an upstream FIFO buffer over ready/valid.
// - Emits each word as RATIO narrow pieces on a downstream ready/valid port, flagging the final piece.
// - Typical use: drains a wide FIFO into a narrow bus or link at full narrow-side rate, with no bubble between words.
//
// PARAMETERS
// - WORD_WIDTH_IN   32   input word width; must be an exact multiple of RATIO.
// - RATIO           4    pieces per input word; must be >= 1.
// - LSB_FIRST       1    1: least-significant piece first; 0: most-significant piece first.
// - WORD_WIDTH_OUT  (localparam) WORD_WIDTH_IN / RATIO.
//
// PORTS
// - clock          in   1                 single clock; all state updates on its rising edge.
// - clear          in   1                 synchronous, active-high reset.
// - input_valid    in   1                 upstream word available.
// - input_ready    out  1                 block accepts a word this cycle.
// - input_data     in   WORD_WIDTH_IN     word to serialize.
// - output_valid   out  1                 output_data holds a valid piece.
// - output_ready   in   1                 downstream takes the piece this cycle.
// - output_data    out  WORD_WIDTH_OUT    current piece.
// - output_last    out  1                 current piece is piece RATIO-1 of its word.
//
// BEHAVIOUR
// - Interface: one clock (clock); reset is synchronous and active-high (clear).
// - Reset and clear: output_valid=0, piece index=0, shift register=0, output_last=0.
//   - input_ready is 1 in the cycle after clear.
//   - A clear mid-word discards the remaining pieces; no partial word is completed afterwards.
//   - clear has priority over any same-cycle handshake.
// - Handshake definitions:
//   - accept = input_valid & input_ready.
//   - send = output_valid & output_ready.
//   - Neither side's valid waits on its own ready.
// - Ready rule: input_ready = !output_valid | (output_last & output_ready).
//   - This is the only combinational path from output_ready to input_ready.
//   - The upstream FIFO absorbs it.
// - States, held in output_valid and the piece index (0..RATIO-1):
//   - IDLE (output_valid=0): on accept -> load the shift register, index=0, output_valid=1.
//   - BUSY, index < RATIO-1: on send -> shift the register by WORD_WIDTH_OUT toward the output end, index++.
//   - BUSY, index == RATIO-1 (output_last=1):
//     - send with accept -> reload, index=0, output_valid stays 1 (no bubble).
//     - send without accept -> output_valid=0, index=0.
// - Latency: first piece is valid the cycle after accept. Throughput: one piece per cycle.
// - Stability: while output_valid & !output_ready, output_data and output_last hold.
// - output_data source:
//   - LSB_FIRST=1: low WORD_WIDTH_OUT bits of the shift register; shift right.
//   - LSB_FIRST=0: high bits; shift left.
//   - Vacated bits fill with 0.
// - output_last = output_valid & (index == RATIO-1).
// - RATIO=1 degenerates to a one-entry pipeline register:
//   - output_last = output_valid.
//   - input_ready = !output_valid | output_ready.
// - Index width = clog2(RATIO), minimum 1. Index wraps only through an explicit load to 0, never by overflow.
//
// STRUCTURE
// - Shared constants via clog2_function.vh: INDEX_WIDTH, INDEX_ZERO, INDEX_LAST = RATIO-1.
// - No package typedefs needed.
// - Piece index: one Counter_Binary instance, configured as:
//   - run on send while not last.
//   - load 0 on send when last, or on accept.
// - Shift register and output_valid: a local always block.
//   - Elaboration check: WORD_WIDTH_IN % RATIO == 0.
//
// TESTING
// - RATIO=4, LSB_FIRST=1, input 0xDDCCBBAA, output_ready=1:
//   - expect 0xAA,0xBB,0xCC,0xDD on consecutive cycles.
//   - output_last only on 0xDD.
//   - input_ready=1 only in the 0xDD cycle.
// - Two back-to-back words 0x44332211, 0x88776655 with output_ready=1:
//   - 8 pieces in 8 consecutive cycles, output_valid never drops.
// - LSB_FIRST=0, input 0xDDCCBBAA, output_ready toggling 1,0,1,0...:
//   - 0xDD,0xCC,0xBB,0xAA, each held stable during stalls.
// - clear asserted after the 2nd piece of 0xDDCCBBAA:
//   - next cycle output_valid=0, input_ready=1.
//   - next word 0x11223344 starts at piece 0x44.
// - RATIO=1, random valid/ready over 1000 cycles:
//   - output stream equals input stream.
//   - output_last == output_valid at every cycle.
// - Upstream FIFO empties mid-stream (input_valid=0 at the last piece):
//   - output_valid=0 next cycle.
//   - resumes 1 cycle after the next accept.

Source files
------------

// File: rtl/pipeline_word_serializer_pkg.sv
// Shared constants and helpers for the word serializer slice.
package pipeline_word_serializer_pkg;

  // Width of a counter that must hold 0..ratio-1; never narrower than one bit.
  function automatic int unsigned index_width(input int unsigned ratio);
    return (ratio <= 1) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/pipeline_word_serializer_if.sv
// Ready/valid stream bundle; word_* modports omit the last flag for plain word streams.
interface pipeline_word_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic             last;
  logic [WIDTH-1:0] data;

  modport master (output valid, data, last, input ready);
  modport slave (input valid, data, last, output ready);
  modport word_master (output valid, data, input ready);
  modport word_slave (input valid, data, output ready);
endinterface

// File: rtl/pipeline_word_serializer_counter.sv
// Binary counter with synchronous clear, load (priority) and run enable.
module pipeline_word_serializer_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (run) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_word_serializer.sv
// Splits each wide input word into RATIO narrow pieces, back to back with no bubble.
module pipeline_word_serializer
  import pipeline_word_serializer_pkg::*;
#(
  parameter int unsigned WORD_WIDTH_IN = 32,
  parameter int unsigned RATIO         = 4,
  parameter bit          LSB_FIRST     = 1'b1
) (
  input  logic                          clock,
  input  logic                          clear,
  pipeline_word_serializer_if.word_slave upstream,
  pipeline_word_serializer_if.master     downstream
);

  localparam int unsigned WORD_WIDTH_OUT = WORD_WIDTH_IN / RATIO;
  localparam int unsigned INDEX_WIDTH    = index_width(RATIO);
  localparam logic [INDEX_WIDTH-1:0] INDEX_ZERO = '0;
  localparam logic [INDEX_WIDTH-1:0] INDEX_LAST = INDEX_WIDTH'(RATIO - 1);

  if (RATIO == 0 || (WORD_WIDTH_IN % RATIO) != 0) begin : g_bad_params
    $error("WORD_WIDTH_IN must be a nonzero multiple of RATIO");
  end

  logic                     valid_q;
  logic [WORD_WIDTH_IN-1:0] shift_q;
  logic [WORD_WIDTH_IN-1:0] shift_next;
  logic [INDEX_WIDTH-1:0]   index;
  logic                     is_last;
  logic                     last;
  logic                     accept;
  logic                     send;

  assign is_last = (index == INDEX_LAST);
  assign last    = valid_q & is_last;
  assign send    = valid_q & downstream.ready;
  // Only combinational path from downstream.ready to upstream.ready.
  assign upstream.ready = !valid_q | (last & downstream.ready);
  assign accept  = upstream.valid & upstream.ready;

  pipeline_word_serializer_counter #(
    .WIDTH (INDEX_WIDTH)
  ) u_index (
    .clock      (clock),
    .clear      (clear),
    .run        (send & !is_last),
    .load       ((send & is_last) | accept),
    .load_value (INDEX_ZERO),
    .count      (index)
  );

  if (LSB_FIRST) begin : g_lsb
    assign shift_next      = shift_q >> WORD_WIDTH_OUT;
    assign downstream.data = shift_q[WORD_WIDTH_OUT-1:0];
  end else begin : g_msb
    assign shift_next      = shift_q << WORD_WIDTH_OUT;
    assign downstream.data = shift_q[WORD_WIDTH_IN-1 -: WORD_WIDTH_OUT];
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      valid_q <= 1'b0;
      shift_q <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      shift_q <= upstream.data;
    end else if (send) begin
      if (is_last) begin
        valid_q <= 1'b0;
      end else begin
        shift_q <= shift_next;
      end
    end
  end

  assign downstream.valid = valid_q;
  assign downstream.last  = last;

endmodule

// File: tb/tb_pipeline_word_serializer.sv
// Three serializer configurations on shared stimulus, checked against a pending-piece model.
module tb_pipeline_word_serializer;

  logic        clock = 1'b0;
  logic        clear;
  logic        up_valid;
  logic [31:0] up_data;
  logic        down_ready;
  logic        en;

  int checks   = 0;
  int failures = 0;

  logic        dv [3];
  logic        dl [3];
  logic        ur [3];
  logic [31:0] dd [3];

  always #5 clock = ~clock;

  // 0: RATIO 4 LSB first, 1: RATIO 4 MSB first, 2: RATIO 1
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned R = (g == 2) ? 1 : 4;
    localparam bit          L = (g != 1);

    pipeline_word_serializer_if #(.WIDTH(32))     up_if ();
    pipeline_word_serializer_if #(.WIDTH(32 / R)) dn_if ();

    assign up_if.valid = up_valid;
    assign up_if.data  = up_data;
    assign up_if.last  = 1'b0;
    assign dn_if.ready = down_ready;

    pipeline_word_serializer #(
      .WORD_WIDTH_IN (32),
      .RATIO         (R),
      .LSB_FIRST     (L)
    ) dut (
      .clock      (clock),
      .clear      (clear),
      .upstream   (up_if),
      .downstream (dn_if)
    );

    assign dv[g] = dn_if.valid;
    assign dl[g] = dn_if.last;
    assign ur[g] = up_if.ready;
    assign dd[g] = 32'(dn_if.data);
  end

  task automatic check(input string name, input int g, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s dut%0d got=%h want=%h at %0t", name, g, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Model: each DUT holds one word and a count of pieces still to be sent.
  int unsigned ratio_m [3] = '{4, 4, 1};
  bit          lsb_m   [3] = '{1'b1, 1'b0, 1'b1};
  int unsigned rem_m   [3] = '{0, 0, 0};
  logic [31:0] word_m  [3];

  always @(negedge clock) begin
    int unsigned w;
    int unsigned k;
    int unsigned sh;
    logic [31:0] mask;
    logic [31:0] ed;
    logic        ev;
    logic        el;
    logic        er;
    for (int g = 0; g < 3; g++) begin
      w    = 32 / ratio_m[g];
      k    = ratio_m[g] - rem_m[g];
      sh   = lsb_m[g] ? k * w : (ratio_m[g] - 1 - k) * w;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      ed   = (word_m[g] >> sh) & mask;
      ev   = (rem_m[g] != 0);
      el   = (rem_m[g] == 1);
      er   = (rem_m[g] == 0) || (rem_m[g] == 1 && down_ready);
      if (en) begin
        check("m_valid", g, 32'(dv[g]), 32'(ev));
        check("m_in_ready", g, 32'(ur[g]), 32'(er));
        check("m_last", g, 32'(dl[g]), 32'(el));
        if (ev) check("m_data", g, dd[g], ed);
        if (g == 2) check("r1_last_eq_valid", g, 32'(dl[g]), 32'(dv[g]));
      end
      if (clear) begin
        rem_m[g] = 0;
      end else begin
        if (ev && down_ready) rem_m[g] = rem_m[g] - 1;
        if (up_valid && er) begin
          word_m[g] = up_data;
          rem_m[g]  = ratio_m[g];
        end
      end
    end
  end

  task automatic drain();
    up_valid   = 1'b0;
    down_ready = 1'b1;
    clear      = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    logic [31:0] e1 [4];
    logic [31:0] e2 [8];
    logic [31:0] e3 [4];
    logic [31:0] got [4];
    int n;

    e1 = '{32'hAA, 32'hBB, 32'hCC, 32'hDD};
    e2 = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88};
    e3 = '{32'hDD, 32'hCC, 32'hBB, 32'hAA};

    en = 1'b0; clear = 1'b1; up_valid = 1'b0; up_data = '0; down_ready = 1'b1;
    tick();
    en = 1'b1; clear = 1'b0;
    @(negedge clock);
    check("reset_valid", 0, 32'(dv[0]), 32'd0);
    check("reset_in_ready", 0, 32'(ur[0]), 32'd1);
    check("reset_last", 0, 32'(dl[0]), 32'd0);

    // LSB-first piece order, last and ready only on the final piece
    up_valid = 1'b1; up_data = 32'hDDCCBBAA;
    tick();
    up_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("s1_data", 0, dd[0], e1[i]);
      check("s1_last", 0, 32'(dl[0]), (i == 3) ? 32'd1 : 32'd0);
      check("s1_in_ready", 0, 32'(ur[0]), (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    @(negedge clock);
    check("s1_idle", 0, 32'(dv[0]), 32'd0);

    // Two words back to back: eight pieces, valid never drops
    drain();
    up_valid = 1'b1; up_data = 32'h44332211;
    tick();
    up_data = 32'h88776655;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("s2_valid", 0, 32'(dv[0]), 32'd1);
      check("s2_data", 0, dd[0], e2[i]);
      tick();
      if (i == 3) up_valid = 1'b0;
    end

    // MSB-first with output_ready toggling
    drain();
    up_valid = 1'b1; up_data = 32'hDDCCBBAA;
    tick();
    up_valid = 1'b0;
    n = 0;
    got = '{32'h0, 32'h0, 32'h0, 32'h0};
    for (int c = 0; c < 12; c++) begin
      down_ready = (c % 2 == 0);
      @(negedge clock);
      if (dv[1] && down_ready && n < 4) begin
        got[n] = dd[1];
        n++;
      end
      tick();
    end
    check("s3_count", 1, 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) check("s3_data", 1, got[i], e3[i]);

    // Clear mid-word discards the rest
    drain();
    up_valid = 1'b1; up_data = 32'hDDCCBBAA;
    tick();
    up_valid = 1'b0;
    @(negedge clock);
    check("s4_piece0", 0, dd[0], 32'hAA);
    tick();
    @(negedge clock);
    check("s4_piece1", 0, dd[0], 32'hBB);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0; up_valid = 1'b1; up_data = 32'h11223344;
    @(negedge clock);
    check("s4_cleared_valid", 0, 32'(dv[0]), 32'd0);
    check("s4_cleared_ready", 0, 32'(ur[0]), 32'd1);
    tick();
    up_valid = 1'b0;
    @(negedge clock);
    check("s4_restart_valid", 0, 32'(dv[0]), 32'd1);
    check("s4_restart_data", 0, dd[0], 32'h44);

    // Upstream empties at the last piece, then resumes
    drain();
    up_valid = 1'b1; up_data = 32'h01020304;
    tick();
    up_valid = 1'b0;
    repeat (3) begin
      @(negedge clock);
      tick();
    end
    @(negedge clock);
    check("s6_last", 0, 32'(dl[0]), 32'd1);
    tick();
    @(negedge clock);
    check("s6_gap", 0, 32'(dv[0]), 32'd0);
    tick();
    up_valid = 1'b1; up_data = 32'hA1B2C3D4;
    @(negedge clock);
    check("s6_still_idle", 0, 32'(dv[0]), 32'd0);
    tick();
    up_valid = 1'b0;
    @(negedge clock);
    check("s6_resume_valid", 0, 32'(dv[0]), 32'd1);
    check("s6_resume_data", 0, dd[0], 32'hD4);

    // Random traffic with occasional clears
    drain();
    for (int c = 0; c < 1000; c++) begin
      up_valid   = ($urandom % 4) != 0;
      up_data    = $urandom;
      down_ready = ($urandom % 3) != 0;
      clear      = ($urandom % 64) == 0;
      tick();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
